// File: rtl/mesi_plru_cache_ctrl_if.sv
// mesi_plru_cache_ctrl_if: command/response bundle between the command driver and one cache controller
interface mesi_plru_cache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int WAYS   = 8
);
  localparam int WW = $clog2(WAYS);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        snoop_in;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [2:0]        rsp_bus_op;
  logic              rsp_evict;
  logic [ADDR_W-1:0] rsp_evict_addr;
  logic [1:0]        rsp_snoop_out;
  logic [WW-1:0]     rsp_way;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
  modport master (
    output cmd_valid, cmd_op, cmd_addr, snoop_in, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_hit, rsp_bus_op, rsp_evict, rsp_evict_addr,
           rsp_snoop_out, rsp_way, hit_cnt, miss_cnt
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, snoop_in, rsp_ready,
    output cmd_ready, rsp_valid, rsp_hit, rsp_bus_op, rsp_evict, rsp_evict_addr,
           rsp_snoop_out, rsp_way, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/mesi_plru_cache_ctrl.sv
// mesi_plru_cache_ctrl: set-associative MESI tag/state controller with tree-PLRU replacement.
// Define CACHE_STATS_EN to build the saturating demand hit/miss counters (tied to 0 otherwise).
module mesi_plru_cache_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int WAYS      = 8,
  parameter int SETS      = 2048,
  parameter int LINE_SIZE = 64
) (
  input logic clk,
  input logic rst_n,
  mesi_plru_cache_ctrl_if.slave bus
);
  localparam int WW = $clog2(WAYS);
  localparam int IW = $clog2(SETS);
  localparam int OW = $clog2(LINE_SIZE);
  localparam int TW = ADDR_W - IW - OW;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
  localparam logic [3:0] OP_RD = 4'd0, OP_WR = 4'd1, OP_IF = 4'd2, OP_INV = 4'd3, OP_DRQ = 4'd4, OP_CLR = 4'd8;
  localparam logic [2:0] BUS_NONE = 3'd0, BUS_RD = 3'd1, BUS_RWIM = 3'd3, BUS_INV = 3'd4;
  typedef enum logic [1:0] {CLEAR, IDLE, LOOKUP, RESP} state_t;
  state_t st, st_nxt;
  logic [IW-1:0] clr_idx;
  logic clr_rsp;
  logic [3:0] op_q;
  logic [TW-1:0] tag_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] tag_mem [SETS][WAYS];
  logic [1:0] mesi_mem [SETS][WAYS];
  logic [WAYS-2:0] plru_mem [SETS];
  logic [WAYS-1:0] hit_vec, inv_vec;
  logic [WW-1:0] hit_way, inv_way, plru_way, vic_way, acc_way, r_way;
  logic [WAYS-2:0] plru_cur, plru_upd;
  logic [1:0] hit_st, vic_st, new_st, r_snoop;
  logic [2:0] r_bus;
  logic [TW-1:0] evict_tag;
  logic hit, demand, wr_en, r_hit, r_evict;
  assign bus.cmd_ready = st == IDLE;
  assign bus.rsp_valid = st == RESP;
  assign plru_cur = plru_mem[idx_q];
  always_comb begin
    hit_vec = '0;
    inv_vec = '0;
    hit_way = '0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = mesi_mem[idx_q][w] != ST_I && tag_mem[idx_q][w] == tag_q;
      inv_vec[w] = mesi_mem[idx_q][w] == ST_I;
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_way = hit_vec[w] ? WW'(w) : hit_way;
      inv_way = inv_vec[w] ? WW'(w) : inv_way;
    end
  end
  // Walk the tree from the root; each node bit picks the half that was used less recently.
  always_comb begin
    int node;
    node = 0;
    plru_way = '0;
    for (int l = 0; l < WW; l++) begin
      plru_way[WW-1-l] = plru_cur[node];
      node = 2 * node + 1 + int'(plru_cur[node]);
    end
  end
  always_comb begin
    int node;
    node = 0;
    plru_upd = plru_cur;
    for (int l = 0; l < WW; l++) begin
      plru_upd[node] = ~acc_way[WW-1-l];
      node = 2 * node + 1 + int'(acc_way[WW-1-l]);
    end
  end
  always_comb begin
    hit = |hit_vec;
    vic_way = |inv_vec ? inv_way : plru_way;
    acc_way = hit ? hit_way : vic_way;
    hit_st = mesi_mem[idx_q][hit_way];
    vic_st = mesi_mem[idx_q][vic_way];
    demand = op_q == OP_RD || op_q == OP_WR || op_q == OP_IF;
    wr_en = 1'b0;
    new_st = hit_st;
    evict_tag = tag_q;
    r_hit = 1'b0;
    r_bus = BUS_NONE;
    r_evict = 1'b0;
    r_snoop = 2'd0;
    r_way = '0;
    if (demand) begin
      wr_en = 1'b1;
      r_hit = hit;
      r_way = acc_way;
      r_evict = !hit && vic_st == ST_M;
      evict_tag = tag_mem[idx_q][vic_way];
      new_st = op_q == OP_WR ? ST_M : hit ? hit_st : bus.snoop_in == 2'd0 ? ST_E : ST_S;
      r_bus = op_q == OP_WR ? (!hit ? BUS_RWIM : hit_st == ST_S ? BUS_INV : BUS_NONE)
                            : (hit ? BUS_NONE : BUS_RD);
    end else if ((op_q == OP_INV || op_q == OP_DRQ) && hit) begin
      wr_en = 1'b1;
      r_hit = 1'b1;
      r_way = hit_way;
      r_evict = hit_st == ST_M;
      new_st = op_q == OP_INV ? ST_I : ST_S;
      r_snoop = op_q == OP_INV ? 2'd0 : hit_st == ST_M ? 2'd2 : 2'd1;
    end
  end
  always_comb begin
    st_nxt = st == CLEAR  ? (&clr_idx ? (clr_rsp ? RESP : IDLE) : CLEAR)
           : st == IDLE   ? (bus.cmd_valid ? LOOKUP : IDLE)
           : st == LOOKUP ? (op_q == OP_CLR ? CLEAR : RESP)
           : (bus.rsp_ready ? IDLE : RESP);
  end
  // Arrays carry no reset: the CLEAR sweep invalidates them one set per cycle.
  always_ff @(posedge clk) begin
    if (st == CLEAR) begin
      for (int w = 0; w < WAYS; w++) mesi_mem[clr_idx][w] <= ST_I;
      plru_mem[clr_idx] <= '0;
    end else if (st == LOOKUP && wr_en) begin
      tag_mem[idx_q][acc_way] <= tag_q;
      mesi_mem[idx_q][acc_way] <= new_st;
      if (demand) plru_mem[idx_q] <= plru_upd;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= CLEAR;
      clr_idx <= '0;
      clr_rsp <= 1'b0;
      op_q <= '0;
      tag_q <= '0;
      idx_q <= '0;
      bus.rsp_hit <= 1'b0;
      bus.rsp_bus_op <= '0;
      bus.rsp_evict <= 1'b0;
      bus.rsp_evict_addr <= '0;
      bus.rsp_snoop_out <= '0;
      bus.rsp_way <= '0;
    end else begin
      st <= st_nxt;
      if (st == CLEAR) clr_idx <= clr_idx + IW'(1);
      if (st == IDLE && bus.cmd_valid) begin
        op_q <= bus.cmd_op;
        tag_q <= bus.cmd_addr[ADDR_W-1 -: TW];
        idx_q <= bus.cmd_addr[OW +: IW];
      end
      if (st == LOOKUP) begin
        clr_rsp <= op_q == OP_CLR;
        bus.rsp_hit <= r_hit;
        bus.rsp_bus_op <= r_bus;
        bus.rsp_evict <= r_evict;
        bus.rsp_evict_addr <= r_evict ? {evict_tag, idx_q, {OW{1'b0}}} : '0;
        bus.rsp_snoop_out <= r_snoop;
        bus.rsp_way <= r_way;
      end
    end
  end
`ifdef CACHE_STATS_EN
  logic [31:0] hit_q, miss_q;
  always_ff @(posedge clk) begin
    if (!rst_n || (st == LOOKUP && op_q == OP_CLR)) begin
      hit_q <= '0;
      miss_q <= '0;
    end else if (st == LOOKUP && demand) begin
      hit_q <= hit_q + 32'(hit && !(&hit_q));
      miss_q <= miss_q + 32'(!hit && !(&miss_q));
    end
  end
  assign bus.hit_cnt = hit_q;
  assign bus.miss_cnt = miss_q;
`else
  assign bus.hit_cnt = '0;
  assign bus.miss_cnt = '0;
`endif
endmodule

// File: doc/mesi_plru_cache_ctrl.md
Name: mesi_plru_cache_ctrl

Overview:
- Parametrised set-associative cache tag/state controller: tag array, 2-bit MESI state per way, tree-PLRU per set.
- Generalises the fixed 8-way/16K-line cache model to any power-of-two WAYS/SETS/LINE_SIZE with a registered command/response handshake.
- Adds a reset/CLR sweep, victim writeback reporting, snoop responses and hit/miss statistics.
- Sits between the trace/command driver and the L2 bus-op model; one instance per L1 (D: WAYS=8, I: WAYS=4).

Parameters:
ADDR_W, 32, address width
WAYS, 8, associativity; power of two, >=2
SETS, 2048, sets; power of two
LINE_SIZE, 64, bytes per line; OFFSET_W=log2(LINE_SIZE), INDEX_W=log2(SETS), TAG_W=ADDR_W-INDEX_W-OFFSET_W

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept
cmd_op  in  4  0 READ, 1 WRITE, 2 I_FETCH, 3 L2_INVAL, 4 L2_DATA_RQ, 8 CLR, 9 PRINT
cmd_addr  in  ADDR_W  byte address
snoop_in  in  2  other-cache result on our miss: 0 NOHIT, 1 HIT, 2 HITM
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_hit  out  1  tag match on valid way
rsp_bus_op  out  3  0 NONE, 1 READ, 2 WRITE, 3 RWIM, 4 INVALIDATE
rsp_evict  out  1  modified line must be written back
rsp_evict_addr  out  ADDR_W  writeback line address, offset bits 0
rsp_snoop_out  out  2  our snoop result: 0 NOHIT, 1 HIT, 2 HITM
rsp_way  out  log2(WAYS)  way hit or allocated
hit_cnt  out  32  demand hits
miss_cnt  out  32  demand misses

Behaviour:
- Reset and decided interface: one clock, clk; rst_n is synchronous, active-low.
- Reset values: every output 0 except cmd_ready (also 0), FSM in CLEAR, set counter at 0.
- FSM states: CLEAR, IDLE, LOOKUP, RESP.
- CLEAR: one set per cycle; all ways set to I, PLRU set to 0. Takes exactly SETS cycles, then goes to IDLE.
- rst_n low at any time, including mid-CLEAR or while RESP is pending, restarts CLEAR from set 0 and drops rsp_valid.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op/addr and go to LOOKUP.
- LOOKUP (1 cycle): compare all ways and update arrays. Go to RESP, or to CLEAR for CLR; CLR's response is issued after the sweep.
- RESP: rsp_valid=1 with all rsp_* fields stable until rsp_ready. Go to IDLE on that cycle.
- Latency: rsp_valid is high 2 cycles after command acceptance (CLR: SETS+2). Back-to-back throughput is one command per 3 cycles.
- Victim selection: lowest-index invalid way; otherwise the PLRU victim.
- PLRU tree: node bit 0 means go left, 1 means go right; the victim is reached by following the bits.
- PLRU update: on a demand access to way w, every node on w's path is set to point away from w. Snoops and L2_INVAL do not touch PLRU.
- READ / I_FETCH:
  - hit: state unchanged, bus NONE.
  - miss: bus READ; install E if snoop_in=NOHIT, else S.
  - If the victim is in M: rsp_evict=1 and rsp_evict_addr={victim_tag,index,0}.
- WRITE:
  - hit M or E: becomes M, bus NONE.
  - hit S: becomes M, bus INVALIDATE.
  - miss: bus RWIM, install M, same eviction rule as READ.
- L2_INVAL: any valid match becomes I; if it was M, rsp_evict=1. rsp_hit reflects the match; bus NONE.
- L2_DATA_RQ:
  - M: becomes S, snoop_out HITM, evict=1.
  - E or S: becomes S, snoop_out HIT.
  - miss: snoop_out NOHIT.
- PRINT and undefined ops: no state change, all fields 0.
- Counters: count READ/WRITE/I_FETCH only; saturate at 2^32-1. CLR and reset zero them.
- snoop_in is sampled in the LOOKUP cycle.

Optional Feature:
CACHE_STATS_EN:
- Defined: hit_cnt and miss_cnt registers exist as specified.
- Undefined: no counter registers; hit_cnt and miss_cnt are tied to 0; all other behaviour identical.

Test Plan:
- rst_n low 1 cycle, then high -> cmd_ready low for exactly 2048 cycles, then 1; all rsp_* 0.
- READ 0x00000000, snoop_in=NOHIT -> rsp after 2 cycles: hit=0, bus READ, way 0, evict=0. Repeat the READ -> hit=1, bus NONE, hit_cnt=1, miss_cnt=1.
- WRITE 0x00000000 -> hit, E to M, bus NONE. Then L2_DATA_RQ 0x00000000 -> snoop_out HITM, evict=1, line S. Then WRITE 0x00000000 -> bus INVALIDATE.
- READs to 0x20000*k for k=1..7, then WRITE 0x00000000, then READ 0x00100000:
  - The first seven fill ways 1..7; the WRITE takes way 0 to M.
  - The final READ evicts the PLRU victim way 4 -> evict=0, way 4.
  - Refill set 0 pattern with way 0 in M and PLRU pointing to 0 -> evict=1, evict_addr 0x00000000.
- rsp_ready held low 5 cycles during RESP -> rsp fields stable, cmd_ready=0. Asserting rst_n low mid-RESP -> rsp_valid 0 next cycle and CLEAR restarts.
- CLR accepted -> rsp after 2050 cycles, counters 0; READ 0x00000000 -> miss.
